pixel_color_writer: RTL and testbench

PIXEL_COLOR_WRITER -- requirements
Module: pixel_color_writer

---
 rtl/mandel_pkg.sv | 41 ++++
 rtl/pixel_color_writer_if.sv | 28 ++
 rtl/rr_arbiter.sv | 46 ++++
 rtl/pixel_color_writer.sv | 137 +++++++++++++
 tb/tb_pixel_color_writer.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mandel_pkg.sv
// rtl/mandel_pkg.sv - constants shared by the Mandelbrot iterator and the pixel color writer
package mandel_pkg;

  localparam int CNT_W      = 11;
  localparam int H_RES      = 640;
  localparam int V_RES      = 480;

  // Iterator coordinates are signed 4.23 fixed point.
  localparam int COORD_W    = 27;
  localparam int COORD_FRAC = 23;
  typedef logic signed [COORD_W-1:0] coord_t;

  localparam int unsigned BAND_64 = 64;
  localparam int unsigned BAND_32 = 32;
  localparam int unsigned BAND_16 = 16;
  localparam int unsigned BAND_8  = 8;
  localparam int unsigned BAND_4  = 4;
  localparam int unsigned BAND_2  = 2;

  localparam logic [7:0] COLOR_IN_SET = 8'h00;
  localparam logic [7:0] COLOR_B64    = 8'hE0;
  localparam logic [7:0] COLOR_B32    = 8'hF0;
  localparam logic [7:0] COLOR_B16    = 8'hFC;
  localparam logic [7:0] COLOR_B8     = 8'h1C;
  localparam logic [7:0] COLOR_B4     = 8'h1F;
  localparam logic [7:0] COLOR_B2     = 8'h03;
  localparam logic [7:0] COLOR_B0     = 8'h49;

  // RGB332 band lookup; the in-set test takes priority over every band.
  function automatic logic [7:0] color_map(input int unsigned count, input int unsigned max_iter);
    if (count >= max_iter)     return COLOR_IN_SET;
    else if (count >= BAND_64) return COLOR_B64;
    else if (count >= BAND_32) return COLOR_B32;
    else if (count >= BAND_16) return COLOR_B16;
    else if (count >= BAND_8)  return COLOR_B8;
    else if (count >= BAND_4)  return COLOR_B4;
    else if (count >= BAND_2)  return COLOR_B2;
    else                       return COLOR_B0;
  endfunction

endpackage

// File: rtl/pixel_color_writer_if.sv
// rtl/pixel_color_writer_if.sv - iterator-result and pixel-memory signal bundle
interface pixel_color_writer_if #(
  parameter int NUM_ITER = 2,
  parameter int CNT_W    = mandel_pkg::CNT_W
);
  logic [NUM_ITER-1:0]       in_valid;
  logic [NUM_ITER-1:0]       in_ready;
  logic [NUM_ITER*10-1:0]    in_x;
  logic [NUM_ITER*9-1:0]     in_y;
  logic [NUM_ITER*CNT_W-1:0] in_count;
  logic                      frame_start;
  logic                      mem_we;
  logic                      mem_ready;
  logic [18:0]               mem_addr;
  logic [7:0]                mem_data;
  logic [18:0]               pixel_count;
  logic                      frame_done;

  modport master (
    output in_valid, in_x, in_y, in_count, frame_start, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_data, pixel_count, frame_done
  );

  modport slave (
    input  in_valid, in_x, in_y, in_count, frame_start, mem_ready,
    output in_ready, mem_we, mem_addr, mem_data, pixel_count, frame_done
  );
endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin grant over N requesters; pointer moves past each accepted grant
module rr_arbiter #(
  parameter int N = 2,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] ptr_q, ptr_d;

  // Scan offsets high to low so the nearest requester at or after ptr wins.
  always_comb begin
    int j;
    logic [IDX_W-1:0] ji;
    grant     = '0;
    grant_idx = ptr_q;
    for (int i = N - 1; i >= 0; i--) begin
      j = int'(ptr_q) + i;
      if (j >= N) j = j - N;
      ji = IDX_W'(j);
      if (req[ji]) begin
        grant     = '0;
        grant[ji] = 1'b1;
        grant_idx = ji;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/pixel_color_writer.sv
// rtl/pixel_color_writer.sv - arbitrates iterator results, maps counts to RGB332, writes VGA memory
module pixel_color_writer #(
  parameter int MAX_ITER = 100,
  parameter int NUM_ITER = 2,
  parameter int CNT_W    = mandel_pkg::CNT_W,
  parameter int H_RES    = mandel_pkg::H_RES,
  parameter int V_RES    = mandel_pkg::V_RES
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_ITER-1:0]       in_valid,
  output logic [NUM_ITER-1:0]       in_ready,
  input  logic [NUM_ITER*10-1:0]    in_x,
  input  logic [NUM_ITER*9-1:0]     in_y,
  input  logic [NUM_ITER*CNT_W-1:0] in_count,
  input  logic                      frame_start,
  output logic                      mem_we,
  input  logic                      mem_ready,
  output logic [18:0]               mem_addr,
  output logic [7:0]                mem_data,
  output logic [18:0]               pixel_count,
  output logic                      frame_done
);

  localparam int IDX_W     = (NUM_ITER > 1) ? $clog2(NUM_ITER) : 1;
  localparam int FRAME_PIX = H_RES * V_RES;

  logic [NUM_ITER-1:0] grant;
  logic [IDX_W-1:0]    grant_idx;
  logic                transfer, a_accept, b_accept, a_in_range, write_done;
  logic [18:0]         a_addr;

  logic             a_valid_q, a_valid_d;
  logic [9:0]       a_x_q, a_x_d;
  logic [8:0]       a_y_q, a_y_d;
  logic [CNT_W-1:0] a_cnt_q, a_cnt_d;
  logic             b_valid_q, b_valid_d;
  logic [18:0]      b_addr_q, b_addr_d;
  logic [7:0]       b_data_q, b_data_d;
  logic [18:0]      pix_cnt_q, pix_cnt_d;
  logic             frame_done_q, frame_done_d;

  rr_arbiter #(.N(NUM_ITER)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (in_valid),
    .advance   (transfer),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // in_ready is gated by reset so nothing is accepted while the pipeline is held clear.
  always_comb begin
    b_accept   = !b_valid_q || mem_ready;
    a_accept   = !a_valid_q || b_accept;
    in_ready   = grant & {NUM_ITER{a_accept & reset}};
    transfer   = |(in_valid & in_ready);
    write_done = b_valid_q & mem_ready;
    a_in_range = (int'(a_x_q) < H_RES) && (int'(a_y_q) < V_RES);
    a_addr     = 19'(int'(a_y_q) * H_RES + int'(a_x_q));
  end

  always_comb begin
    a_valid_d = a_valid_q;
    a_x_d     = a_x_q;
    a_y_d     = a_y_q;
    a_cnt_d   = a_cnt_q;
    if (a_accept) begin
      a_valid_d = transfer;
      if (transfer) begin
        a_x_d   = in_x[int'(grant_idx) * 10 +: 10];
        a_y_d   = in_y[int'(grant_idx) * 9 +: 9];
        a_cnt_d = in_count[int'(grant_idx) * CNT_W +: CNT_W];
      end
    end
  end

  // Off-screen pixels die here: they never become a stage B entry.
  always_comb begin
    b_valid_d = b_valid_q;
    b_addr_d  = b_addr_q;
    b_data_d  = b_data_q;
    if (b_accept) begin
      b_valid_d = a_valid_q && a_in_range;
      if (a_valid_q && a_in_range) begin
        b_addr_d = a_addr;
        b_data_d = mandel_pkg::color_map(32'(a_cnt_q), 32'(MAX_ITER));
      end
    end
  end

  always_comb begin
    pix_cnt_d    = pix_cnt_q;
    frame_done_d = 1'b0;
    if (frame_start) begin
      pix_cnt_d = '0;
    end else if (write_done) begin
      if (pix_cnt_q == 19'(FRAME_PIX - 1)) begin
        pix_cnt_d    = '0;
        frame_done_d = 1'b1;
      end else begin
        pix_cnt_d = pix_cnt_q + 19'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_valid_q    <= 1'b0;
      a_x_q        <= '0;
      a_y_q        <= '0;
      a_cnt_q      <= '0;
      b_valid_q    <= 1'b0;
      b_addr_q     <= '0;
      b_data_q     <= '0;
      pix_cnt_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      a_valid_q    <= a_valid_d;
      a_x_q        <= a_x_d;
      a_y_q        <= a_y_d;
      a_cnt_q      <= a_cnt_d;
      b_valid_q    <= b_valid_d;
      b_addr_q     <= b_addr_d;
      b_data_q     <= b_data_d;
      pix_cnt_q    <= pix_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign mem_we      = b_valid_q;
  assign mem_addr    = b_addr_q;
  assign mem_data    = b_data_q;
  assign pixel_count = pix_cnt_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_pixel_color_writer.sv
// tb/tb_pixel_color_writer.sv - self-checking bench for pixel_color_writer
module tb_pixel_color_writer;

  localparam int FRAME = 640 * 480;

  logic clk;
  logic reset;

  pixel_color_writer_if #(.NUM_ITER(2), .CNT_W(11)) mif ();
  pixel_color_writer_if #(.NUM_ITER(2), .CNT_W(11)) sif ();

  pixel_color_writer #(.MAX_ITER(100), .NUM_ITER(2), .CNT_W(11), .H_RES(640), .V_RES(480)) dut (
    .clk(clk), .reset(reset),
    .in_valid(mif.in_valid), .in_ready(mif.in_ready), .in_x(mif.in_x), .in_y(mif.in_y),
    .in_count(mif.in_count), .frame_start(mif.frame_start), .mem_we(mif.mem_we),
    .mem_ready(mif.mem_ready), .mem_addr(mif.mem_addr), .mem_data(mif.mem_data),
    .pixel_count(mif.pixel_count), .frame_done(mif.frame_done)
  );

  pixel_color_writer #(.MAX_ITER(100), .NUM_ITER(2), .CNT_W(11), .H_RES(4), .V_RES(2)) dut_s (
    .clk(clk), .reset(reset),
    .in_valid(sif.in_valid), .in_ready(sif.in_ready), .in_x(sif.in_x), .in_y(sif.in_y),
    .in_count(sif.in_count), .frame_start(sif.frame_start), .mem_we(sif.mem_we),
    .mem_ready(sif.mem_ready), .mem_addr(sif.mem_addr), .mem_data(sif.mem_data),
    .pixel_count(sif.pixel_count), .frame_done(sif.frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ref_color(input int c);
    if (c >= 100) return 'h00;
    if (c >= 64)  return 'hE0;
    if (c >= 32)  return 'hF0;
    if (c >= 16)  return 'hFC;
    if (c >= 8)   return 'h1C;
    if (c >= 4)   return 'h1F;
    if (c >= 2)   return 'h03;
    return 'h49;
  endfunction

  task automatic set_ch(input int ch, input int x, input int y, input int cnt);
    mif.in_x[ch*10 +: 10]     = 10'(x);
    mif.in_y[ch*9 +: 9]       = 9'(y);
    mif.in_count[ch*11 +: 11] = 11'(cnt);
  endtask

  // Transaction-level reference: expected writes in order, pointer, frame counter.
  typedef struct { int addr; int data; } exp_t;
  exp_t sb[$];
  int   m_ptr, m_pc;
  logic m_fd, hold_v;
  logic [18:0] hold_addr;
  logic [7:0]  hold_data;

  always @(negedge clk) begin
    int eg;
    int c;
    int x, y, cnt;
    exp_t e;
    if (!reset) begin
      sb.delete();
      m_ptr = 0; m_pc = 0; m_fd = 1'b0; hold_v = 1'b0;
      check("rst_we", 32'(mif.mem_we), 0);
      check("rst_in_ready", 32'(mif.in_ready), 0);
      check("rst_pc", 32'(mif.pixel_count), 0);
    end else begin
      check("pixel_count", 32'(mif.pixel_count), 32'(m_pc));
      check("frame_done", 32'(mif.frame_done), 32'(m_fd));
      if (hold_v) begin
        check("hold_we", 32'(mif.mem_we), 1);
        check("hold_addr", 32'(mif.mem_addr), 32'(hold_addr));
        check("hold_data", 32'(mif.mem_data), 32'(hold_data));
      end
      hold_v    = mif.mem_we && !mif.mem_ready;
      hold_addr = mif.mem_addr;
      hold_data = mif.mem_data;
      if (mif.mem_we && mif.mem_ready) begin
        check("write_expected", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("wr_addr", 32'(mif.mem_addr), 32'(e.addr));
          check("wr_data", 32'(mif.mem_data), 32'(e.data));
        end
      end
      eg = -1;
      for (int k = 0; k < 2; k++) begin
        c = (m_ptr + k) % 2;
        if (eg < 0 && mif.in_valid[c]) eg = c;
      end
      if (mif.in_ready != 2'b00) begin
        check("grant", 32'(mif.in_ready), (eg < 0) ? 0 : (1 << eg));
        if (eg >= 0 && mif.in_valid[eg] && mif.in_ready[eg]) begin
          x   = int'(mif.in_x[eg*10 +: 10]);
          y   = int'(mif.in_y[eg*9 +: 9]);
          cnt = int'(mif.in_count[eg*11 +: 11]);
          if (x < 640 && y < 480) begin
            e.addr = y * 640 + x;
            e.data = ref_color(cnt);
            sb.push_back(e);
          end
          m_ptr = (eg + 1) % 2;
        end
      end
      if (mif.frame_start) begin
        m_pc = 0; m_fd = 1'b0;
      end else if (mif.mem_we && mif.mem_ready) begin
        m_fd = (m_pc + 1 == FRAME);
        m_pc = m_fd ? 0 : m_pc + 1;
      end else begin
        m_fd = 1'b0;
      end
    end
  end

  task automatic single(input int x, input int y, input int cnt, input int addr, input int data);
    @(posedge clk); #1;
    set_ch(0, x, y, cnt);
    mif.in_valid = 2'b01;
    @(negedge clk);
    check("single_ready", 32'(mif.in_ready), 1);
    @(posedge clk); #1;
    mif.in_valid = 2'b00;
    @(negedge clk);
    check("single_we_t1", 32'(mif.mem_we), 0);
    @(negedge clk);
    check("single_we_t2", 32'(mif.mem_we), 1);
    check("single_addr", 32'(mif.mem_addr), 32'(addr));
    check("single_data", 32'(mif.mem_data), 32'(data));
  endtask

  typedef struct { int x; int y; int cnt; int addr; int data; } vec_t;
  vec_t vecs[17];

  initial begin
    int pc_before, s_pc, fd_seen, wraps, fs_hit;
    logic s_fd, wr;

    vecs[0]  = '{5, 2, 100, 1285, 'h00};
    vecs[1]  = '{0, 0, 0, 0, 'h49};
    vecs[2]  = '{639, 479, 1, 307199, 'h49};
    vecs[3]  = '{10, 1, 2, 650, 'h03};
    vecs[4]  = '{3, 0, 99, 3, 'hE0};
    vecs[5]  = '{1, 1, 4, 641, 'h1F};
    vecs[6]  = '{2, 2, 7, 1282, 'h1F};
    vecs[7]  = '{8, 0, 8, 8, 'h1C};
    vecs[8]  = '{0, 3, 15, 1920, 'h1C};
    vecs[9]  = '{0, 0, 16, 0, 'hFC};
    vecs[10] = '{5, 5, 31, 3205, 'hFC};
    vecs[11] = '{0, 0, 32, 0, 'hF0};
    vecs[12] = '{0, 0, 63, 0, 'hF0};
    vecs[13] = '{0, 0, 64, 0, 'hE0};
    vecs[14] = '{0, 0, 2047, 0, 'h00};
    vecs[15] = '{0, 0, 3, 0, 'h03};
    vecs[16] = '{1, 0, 1, 1, 'h49};

    mif.in_valid = '0; mif.in_x = '0; mif.in_y = '0; mif.in_count = '0;
    mif.frame_start = 1'b0; mif.mem_ready = 1'b1;
    sif.in_valid = '0; sif.in_x = '0; sif.in_y = '0; sif.in_count = '0;
    sif.frame_start = 1'b0; sif.mem_ready = 1'b1;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("rst0_we", 32'(mif.mem_we), 0);
    check("rst0_addr", 32'(mif.mem_addr), 0);
    check("rst0_data", 32'(mif.mem_data), 0);
    check("rst0_fd", 32'(mif.frame_done), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    foreach (vecs[i]) single(vecs[i].x, vecs[i].y, vecs[i].cnt, vecs[i].addr, vecs[i].data);

    // Contention: ptr is 1 after the channel-0 singles, so channel 1 goes first.
    @(posedge clk); #1;
    set_ch(0, 1, 0, 3);
    set_ch(1, 2, 0, 40);
    mif.in_valid = 2'b11;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("cont_grant", 32'(mif.in_ready), (k % 2 == 0) ? 2 : 1);
      if (k >= 2) begin
        check("cont_we", 32'(mif.mem_we), 1);
        check("cont_data", 32'(mif.mem_data), (k % 2 == 0) ? 'hF0 : 'h03);
        check("cont_addr", 32'(mif.mem_addr), (k % 2 == 0) ? 2 : 1);
      end
    end
    @(posedge clk); #1 mif.in_valid = 2'b00;
    repeat (3) @(negedge clk);

    // Backpressure: both stages fill, then 5 stalled cycles.
    @(posedge clk); #1;
    mif.mem_ready = 1'b0;
    set_ch(0, 10, 1, 5);
    set_ch(1, 11, 1, 70);
    mif.in_valid = 2'b11;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        check("bp_in_ready", 32'(mif.in_ready), 0);
        check("bp_we", 32'(mif.mem_we), 1);
        check("bp_addr", 32'(mif.mem_addr), 651);
        check("bp_data", 32'(mif.mem_data), 'hE0);
      end
    end
    @(posedge clk); #1 mif.mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 mif.in_valid = 2'b00;
    repeat (4) @(negedge clk);
    check("bp_drained", 32'(sb.size()), 0);

    // Out of range: accepted, never written, not counted.
    pc_before = m_pc;
    @(posedge clk); #1;
    set_ch(0, 640, 0, 5);
    mif.in_valid = 2'b01;
    @(negedge clk);
    check("oor_x_ready", 32'(mif.in_ready), 1);
    @(posedge clk); #1;
    set_ch(0, 0, 480, 5);
    @(negedge clk);
    check("oor_y_ready", 32'(mif.in_ready), 1);
    @(posedge clk); #1 mif.in_valid = 2'b00;
    repeat (4) begin
      @(negedge clk);
      check("oor_no_we", 32'(mif.mem_we), 0);
      check("oor_pc", 32'(mif.pixel_count), 32'(pc_before));
    end
    single(7, 0, 9, 7, 'h1C);

    // Random traffic against the scoreboard.
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(posedge clk); #1;
      mif.in_valid = 2'($urandom_range(0, 3));
      for (int ch = 0; ch < 2; ch++)
        set_ch(ch, $urandom_range(0, 700), $urandom_range(0, 511),
               ($urandom_range(0, 1) == 1) ? $urandom_range(0, 130) : $urandom_range(0, 2047));
      mif.mem_ready   = ($urandom_range(0, 3) != 0);
      mif.frame_start = ($urandom_range(0, 31) == 0);
    end
    @(posedge clk); #1;
    mif.in_valid = 2'b00; mif.mem_ready = 1'b1; mif.frame_start = 1'b0;
    repeat (5) @(negedge clk);
    check("rand_drained", 32'(sb.size()), 0);

    // Reset with stage B full and stalled: mem_we must drop without a clock edge.
    @(posedge clk); #1;
    mif.mem_ready = 1'b0;
    set_ch(0, 3, 3, 20);
    mif.in_valid = 2'b01;
    @(posedge clk); #1 mif.in_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    check("mid_we_before", 32'(mif.mem_we), 1);
    check("mid_addr_before", 32'(mif.mem_addr), 1923);
    check("mid_data_before", 32'(mif.mem_data), 'hFC);
    #2;
    mif.in_valid = 2'b11;
    reset = 1'b0;
    #1;
    check("mid_we_async", 32'(mif.mem_we), 0);
    check("mid_addr_async", 32'(mif.mem_addr), 0);
    check("mid_data_async", 32'(mif.mem_data), 0);
    check("mid_ready_async", 32'(mif.in_ready), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    mif.mem_ready = 1'b1;
    set_ch(0, 4, 0, 1);
    set_ch(1, 9, 9, 9);
    @(negedge clk);
    check("mid_ptr_reset", 32'(mif.in_ready), 1);
    @(posedge clk); #1 mif.in_valid = 2'b00;
    @(negedge clk);
    check("mid_we_t1", 32'(mif.mem_we), 0);
    @(negedge clk);
    check("mid_we_t2", 32'(mif.mem_we), 1);
    check("mid_addr_t2", 32'(mif.mem_addr), 4);
    check("mid_data_t2", 32'(mif.mem_data), 'h49);
    repeat (2) @(negedge clk);

    // Frame wrap on the 4x2 instance, then frame_start colliding with an 8th write.
    s_pc = 0; s_fd = 1'b0; fd_seen = 0; wraps = 0; fs_hit = 0;
    @(posedge clk); #1;
    sif.in_valid = 2'b01;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      check("s_pc", 32'(sif.pixel_count), 32'(s_pc));
      check("s_fd", 32'(sif.frame_done), 32'(s_fd));
      if (sif.frame_done) fd_seen++;
      wr = sif.mem_we && sif.mem_ready;
      sif.frame_start = wr && (s_pc == 7) && (wraps == 1);
      if (sif.frame_start) begin
        s_pc = 0; s_fd = 1'b0; fs_hit++;
      end else if (wr) begin
        s_fd = (s_pc == 7);
        s_pc = s_fd ? 0 : s_pc + 1;
        if (s_fd) wraps++;
      end else begin
        s_fd = 1'b0;
      end
      @(posedge clk); #1;
      sif.frame_start = 1'b0;
      sif.in_x[9:0]      = 10'(c % 4);
      sif.in_y[8:0]      = 9'((c / 4) % 2);
      sif.in_count[10:0] = 11'(c);
    end
    sif.in_valid = 2'b00;
    check("s_fd_pulses", 32'(fd_seen), 1);
    check("s_fs_collision", 32'(fs_hit), 1);
    check("s_pc_final", 32'(sif.pixel_count), 6);

    check("sb_empty", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
